// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single byte-addressed unified memory of the multicycle MIPS
// between the instruction-fetch requester (read-only) and the data
// load/store requester. One access is in flight at a time; each access is
// sequenced IDLE -> WAIT (WAIT_CYCLES+1 memory cycles) -> RESP (ack pulse).
// Ties between the two requesters are broken round-robin.
//
// Parameters
//   WAIT_CYCLES  extra access cycles after the first memory cycle (0 = single)
//   FETCH_FIRST  0: data wins the first tie after reset, 1: fetch wins it
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   i_req/i_adr       fetch request (held until i_ack) and byte address
//   i_ack/i_rdata     fetch complete pulse and registered fetch data
//   d_req/d_we/d_adr/d_wdata
//                     data request (held until d_ack), store flag,
//                     byte address, store data
//   d_ack/d_rdata     data complete pulse and registered load data
//   d_err             (MEM_ARB_ALIGN_CHK_EN only) misaligned data access
//   m_adr/m_din       memory address / write data, latched at grant
//   m_rd/m_wr         memory read / write enables
//   m_dout            memory read data (combinational from memory)
//
// Build option
//   MEM_ARB_ALIGN_CHK_EN  when defined, a granted data access whose address
//                         is not word aligned bypasses memory and completes
//                         with d_ack and d_err pulsing together.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter bit FETCH_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_adr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
`ifdef MEM_ARB_ALIGN_CHK_EN
  output logic        d_err,
`endif
  output logic [31:0] m_adr,
  output logic [31:0] m_din,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [31:0] m_dout
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             own_fetch_q, own_fetch_d;   // owner of the access in flight
  logic             we_q, we_d;                 // access in flight is a store
  logic             last_fetch_q, last_fetch_d; // fetch was granted most recently
  logic             grant;
  logic             grant_fetch;
  logic             capture;
`ifdef MEM_ARB_ALIGN_CHK_EN
  logic             err_q, err_d;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    own_fetch_d  = own_fetch_q;
    we_d         = we_q;
    last_fetch_d = last_fetch_q;
    grant        = 1'b0;
    grant_fetch  = 1'b0;
    capture      = 1'b0;
    m_rd         = 1'b0;
    m_wr         = 1'b0;
    i_ack        = 1'b0;
    d_ack        = 1'b0;
`ifdef MEM_ARB_ALIGN_CHK_EN
    err_d        = err_q;
    d_err        = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // Fetch wins when alone, or on a tie when data was granted last.
        grant_fetch = i_req && (!d_req || !last_fetch_q);
        if (i_req || d_req) begin
          grant        = 1'b1;
          own_fetch_d  = grant_fetch;
          we_d         = grant_fetch ? 1'b0 : d_we;
          last_fetch_d = grant_fetch;
          cnt_d        = CNT_W'(WAIT_CYCLES);
          state_d      = ST_WAIT;
`ifdef MEM_ARB_ALIGN_CHK_EN
          err_d        = 1'b0;
          if (!grant_fetch && (d_adr[1:0] != 2'b00)) begin
            // Misaligned data access never touches memory.
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
`endif
        end
      end

      ST_WAIT: begin
        m_rd = !we_q;
        // The write strobe is confined to the last wait cycle so a reset
        // earlier in the access aborts the store without touching memory.
        m_wr = we_q && (cnt_q == '0);
        if (cnt_q == '0) begin
          capture = !we_q;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_RESP: begin
        i_ack   = own_fetch_q;
        d_ack   = !own_fetch_q;
`ifdef MEM_ARB_ALIGN_CHK_EN
        d_err   = !own_fetch_q && err_q;
`endif
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      own_fetch_q  <= 1'b0;
      we_q         <= 1'b0;
      // Pretend the "other" side won last so the first tie goes to FETCH_FIRST.
      last_fetch_q <= ~FETCH_FIRST;
      m_adr        <= '0;
      m_din        <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
`ifdef MEM_ARB_ALIGN_CHK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      own_fetch_q  <= own_fetch_d;
      we_q         <= we_d;
      last_fetch_q <= last_fetch_d;
`ifdef MEM_ARB_ALIGN_CHK_EN
      err_q        <= err_d;
`endif
      if (grant) begin
        m_adr <= grant_fetch ? i_adr : d_adr;
        if (!grant_fetch) begin
          m_din <= d_wdata;
        end
      end
      if (capture) begin
        if (own_fetch_q) begin
          i_rdata <= m_dout;
        end else begin
          d_rdata <= m_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter (WAIT_CYCLES=1, FETCH_FIRST=0) with a
// 256-byte little-endian memory model wrapping on m_adr[7:0]. Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int WC = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_adr, d_adr, d_wdata;
  logic        i_ack, d_ack, m_rd, m_wr;
  logic [31:0] i_rdata, d_rdata, m_adr, m_din, m_dout;
`ifdef MEM_ARB_ALIGN_CHK_EN
  logic        d_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_CYCLES(WC), .FETCH_FIRST(1'b0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (i_req),
    .i_adr   (i_adr),
    .i_ack   (i_ack),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_adr   (d_adr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
`ifdef MEM_ARB_ALIGN_CHK_EN
    .d_err   (d_err),
`endif
    .m_adr   (m_adr),
    .m_din   (m_din),
    .m_rd    (m_rd),
    .m_wr    (m_wr),
    .m_dout  (m_dout)
  );

  // Memory model
  logic [7:0] mem [0:255];
  logic [7:0] a0, a1, a2, a3;
  assign a0     = m_adr[7:0];
  assign a1     = a0 + 8'd1;
  assign a2     = a0 + 8'd2;
  assign a3     = a0 + 8'd3;
  assign m_dout = {mem[a3], mem[a2], mem[a1], mem[a0]};

  always @(posedge clk) begin
    if (m_wr) begin
      mem[a0] <= m_din[7:0];
      mem[a1] <= m_din[15:8];
      mem[a2] <= m_din[23:16];
      mem[a3] <= m_din[31:24];
    end
  end

  bit wr_seen;
  always @(posedge m_wr) wr_seen = 1'b1;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    logic [7:0] b1, b2, b3;
    b1 = a + 8'd1;
    b2 = a + 8'd2;
    b3 = a + 8'd3;
    return {mem[b3], mem[b2], mem[b1], mem[a]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one access starting in an IDLE cycle; returns ack latency in cycles
  // (-1 if the bound expires), memory strobe counts and protocol errors.
  task automatic access(input bit fetch, input bit we, input logic [31:0] adr,
                        input logic [31:0] wdata, output int lat, output int nrd,
                        output int nwr, output bit both, output bit wrong_ack);
    lat = -1; nrd = 0; nwr = 0; both = 1'b0; wrong_ack = 1'b0;
    if (fetch) begin
      i_req = 1'b1; i_adr = adr;
    end else begin
      d_req = 1'b1; d_we = we; d_adr = adr; d_wdata = wdata;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (m_rd) nrd++;
      if (m_wr) nwr++;
      if (m_rd && m_wr) both = 1'b1;
      if (fetch ? d_ack : i_ack) wrong_ack = 1'b1;
      if (fetch ? i_ack : d_ack) begin
        lat = k;
        break;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    bit          fetch;
    bit          we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, nrd, nwr;
    bit both, wrong;
    logic [31:0] saved;
    int d_at1, d_at2, i_at, d_cnt;
    bit i_seen;

    vecs[0] = '{"fetch10",  1'b1, 1'b0, 32'h10, 32'h0,        32'h12345678, 32'h0};
    vecs[1] = '{"store20",  1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 32'h12345678, 32'h0};
    vecs[2] = '{"load20",   1'b0, 1'b0, 32'h20, 32'h0,        32'h12345678, 32'hDEADBEEF};
    vecs[3] = '{"fetch20",  1'b1, 1'b0, 32'h20, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    vecs[4] = '{"store30",  1'b0, 1'b1, 32'h30, 32'hA5A50F0F, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[5] = '{"load30",   1'b0, 1'b0, 32'h30, 32'h0,        32'hDEADBEEF, 32'hA5A50F0F};
    vecs[6] = '{"load10",   1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 32'h12345678};
    vecs[7] = '{"fetch30",  1'b1, 1'b0, 32'h30, 32'h0,        32'hA5A50F0F, 32'h12345678};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h78; mem[8'h11] = 8'h56; mem[8'h12] = 8'h34; mem[8'h13] = 8'h12;

    // Reset with random inputs: every output must stay at zero.
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      i_req   = 1'($urandom_range(0, 1));
      d_req   = 1'($urandom_range(0, 1));
      d_we    = 1'($urandom_range(0, 1));
      i_adr   = $urandom();
      d_adr   = $urandom();
      d_wdata = $urandom();
      @(negedge clk);
      check("rst_strobes", {28'h0, i_ack, d_ack, m_rd, m_wr}, 32'h0);
      check("rst_rdata", i_rdata | d_rdata, 32'h0);
      check("rst_mbus", m_adr | m_din, 32'h0);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle_quiet", {28'h0, i_ack, d_ack, m_rd, m_wr}, 32'h0);
    end

    // Single-requester accesses
    for (int v = 0; v < 8; v++) begin
      access(vecs[v].fetch, vecs[v].we, vecs[v].adr, vecs[v].wdata, lat, nrd, nwr, both, wrong);
      check({vecs[v].name, "_latency"}, lat, WC + 2);
      check({vecs[v].name, "_rd_cycles"}, nrd, vecs[v].we ? 0 : WC + 1);
      check({vecs[v].name, "_wr_cycles"}, nwr, vecs[v].we ? 1 : 0);
      check({vecs[v].name, "_rd_wr_overlap"}, {31'h0, both}, 32'h0);
      check({vecs[v].name, "_wrong_ack"}, {31'h0, wrong}, 32'h0);
      check({vecs[v].name, "_i_rdata"}, i_rdata, vecs[v].exp_i);
      check({vecs[v].name, "_d_rdata"}, d_rdata, vecs[v].exp_d);
      check({vecs[v].name, "_m_adr"}, m_adr, vecs[v].adr);
      if (vecs[v].we) check({vecs[v].name, "_m_din"}, m_din, vecs[v].wdata);
    end
    check("mem20_after_store", mem_word(8'h20), 32'hDEADBEEF);

    // Misaligned data load at 0x22
    saved = d_rdata;
`ifdef MEM_ARB_ALIGN_CHK_EN
    d_req = 1'b1; d_we = 1'b0; d_adr = 32'h22;
    @(negedge clk);
    check("mis_ack_err", {30'h0, d_ack, d_err}, 32'h3);
    check("mis_no_mem", {30'h0, m_rd, m_wr}, 32'h0);
    d_req = 1'b0;
    @(negedge clk);
    check("mis_single_pulse", {30'h0, d_ack, d_err}, 32'h0);
    check("mis_d_rdata_held", d_rdata, saved);
`else
    access(1'b0, 1'b0, 32'h22, 32'h0, lat, nrd, nwr, both, wrong);
    check("mis_latency", lat, WC + 2);
    check("mis_rd_cycles", nrd, WC + 1);
    check("mis_m_adr", m_adr, 32'h22);
    check("mis_d_rdata", d_rdata, 32'h0000DEAD);
    check("mis_i_rdata_held", i_rdata, 32'hA5A50F0F);
    if (saved == 32'h0000DEAD) check("mis_rdata_changed", saved, 32'h12345678);
`endif

    // Tie after reset: data first, then fetch (data re-requests at once),
    // then data again.
    apply_reset();
    d_at1 = -1; d_at2 = -1; i_at = -1; d_cnt = 0; i_seen = 1'b0;
    i_req = 1'b1; i_adr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_adr = 32'h30;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (d_ack) begin
        d_cnt++;
        if (d_cnt == 1) d_at1 = k;
        else begin
          d_at2 = k;
          d_req = 1'b0;
        end
      end
      if (i_ack) begin
        i_at   = k;
        i_seen = 1'b1;
        i_req  = 1'b0;
      end
      if (d_cnt >= 2 && i_seen) break;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    check("tie_first_data_ack", d_at1, WC + 2);
    check("tie_fetch_ack", i_at, 2 * (WC + 3) + 1 - 2 + 1 - 1 + 0 == 0 ? 0 : 2 * (WC + 3) - 1);
    check("tie_second_data_ack", d_at2, 3 * (WC + 3) - 1);
    check("tie_i_rdata", i_rdata, 32'h12345678);
    check("tie_d_rdata", d_rdata, 32'hA5A50F0F);
    @(negedge clk);

    // Reset during the first wait cycle of a store aborts it.
    apply_reset();
    wr_seen = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_adr = 32'h20; d_wdata = 32'h11223344;
    @(posedge clk);
    #2;
    check("abort_no_wr_before_rst", {31'h0, m_wr}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("abort_strobes", {28'h0, i_ack, d_ack, m_rd, m_wr}, 32'h0);
    check("abort_mbus", m_adr | m_din, 32'h0);
    d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_after_quiet", {28'h0, i_ack, d_ack, m_rd, m_wr}, 32'h0);
    end
    check("abort_wr_seen", {31'h0, wr_seen}, 32'h0);
    check("abort_mem20", mem_word(8'h20), 32'hDEADBEEF);
    check("abort_rdata", i_rdata | d_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
